// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl -- scrolling message controller for an 8-digit,
// multiplexed, active-low seven-segment display.
//
// A message of up to MSG_DEPTH segment patterns is streamed in with a
// valid/ready handshake.
// - Messages of 8 characters or fewer are shown statically, left-justified.
// - Longer messages scroll left by one character every STEP_DIV cycles and
//   wrap around.
// - The digit scan runs continuously from reset, selecting each digit for
//   SCAN_DIV cycles.
//
// Optional feature, macro SEG7_SCROLL_BLINK_EN: adds parameter BLINK_DIV and
// input blink_i, which blanks the segments on alternate BLINK_DIV-cycle
// periods while a message is on screen.
//
// Ports
//   clk_i         clock, rising edge
//   arstn_i       asynchronous active-low reset
//   char_valid_i  a character is offered on char_i
//   char_i        segment pattern {a,b,c,d,e,f,g,dp}, active-low
//   char_last_i   the offered character ends the message
//   char_ready_o  the controller accepts a character this cycle
//   stop_i        abort the display and discard the message
//   busy_o        a message is on screen (SHOW or SCROLL)
//   an_o          digit anodes, active-low one-hot; an_o[7] is the leftmost
//   seg_o         segment drive {a..g,dp}, active-low
//   blink_i       (SEG7_SCROLL_BLINK_EN only) blink the message
module seg7_scroll_ctrl #(
    parameter int MSG_DEPTH = 16,
    parameter int SCAN_DIV  = 1024,
    parameter int STEP_DIV  = 2**24
`ifdef SEG7_SCROLL_BLINK_EN
    ,
    parameter int BLINK_DIV = 2**25
`endif
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       char_valid_i,
    input  logic [7:0] char_i,
    input  logic       char_last_i,
    output logic       char_ready_o,
    input  logic       stop_i,
    output logic       busy_o,
    output logic [7:0] an_o,
    output logic [7:0] seg_o
`ifdef SEG7_SCROLL_BLINK_EN
    ,
    input  logic       blink_i
`endif
);

    localparam int LW  = $clog2(MSG_DEPTH + 1);  // holds 0..MSG_DEPTH
    localparam int IW  = $clog2(MSG_DEPTH);      // buffer index
    // Wide enough for offset + 7 and for the constant 8.
    localparam int SW  = ((LW > 3) ? LW : 3) + 1;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int STW = $clog2(STEP_DIV);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SHOW   = 2'd2;
    localparam logic [1:0] SCROLL = 2'd3;

    logic [1:0]     state_reg, state_next;
    logic [LW-1:0]  len_reg, len_next;
    logic [IW-1:0]  offset_reg, offset_next;
    logic [STW-1:0] step_reg, step_next;
    logic [SCW-1:0] scan_reg;
    logic [2:0]     dig_reg;
    logic           ready_reg;
    logic [7:0]     an_reg, seg_reg;
    logic           blank;

    // Message storage has no reset: len_reg alone says which entries are valid.
    logic [7:0] buffer [MSG_DEPTH];

    logic          accept;
    logic          last_char;
    logic [LW-1:0] len_inc;

    assign accept    = char_valid_i && ready_reg && !stop_i;
    // The character that fills the last slot always ends the message.
    assign last_char = char_last_i || (len_reg == LW'(MSG_DEPTH - 1));
    assign len_inc   = len_reg + LW'(1);

    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        offset_next = offset_reg;
        step_next   = step_reg;
        if (stop_i) begin
            state_next  = IDLE;
            len_next    = '0;
            offset_next = '0;
            step_next   = '0;
        end else begin
            case (state_reg)
                IDLE, LOAD: begin
                    if (accept) begin
                        len_next = len_inc;
                        if (last_char) begin
                            state_next = (SW'(len_inc) <= SW'(8)) ? SHOW : SCROLL;
                        end else begin
                            state_next = LOAD;
                        end
                    end
                end
                SCROLL: begin
                    if (step_reg == STW'(STEP_DIV - 1)) begin
                        step_next   = '0;
                        offset_next = (LW'(offset_reg) == len_reg - LW'(1)) ?
                                      '0 : offset_reg + IW'(1);
                    end else begin
                        step_next = step_reg + STW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            buffer[IW'(len_reg)] <= char_i;
        end
    end

    // Display path. pos is the character slot of the currently scanned digit
    // counted from the left; in SCROLL it is rotated by offset modulo len.
    // Since offset < len and len > 8 there, a single subtraction is enough.
    logic [2:0]    pos;
    logic [SW-1:0] sum_raw, sum_wrap;
    logic [IW-1:0] rd_idx;
    logic          display_on;
    logic          show_pad;
    logic [7:0]    seg_next;

    assign pos        = 3'd7 - dig_reg;
    assign sum_raw    = SW'(offset_reg) + SW'(pos);
    assign sum_wrap   = ((state_reg == SCROLL) && (sum_raw >= SW'(len_reg))) ?
                        sum_raw - SW'(len_reg) : sum_raw;
    assign rd_idx     = IW'(sum_wrap);
    assign display_on = (state_reg == SHOW) || (state_reg == SCROLL);
    assign show_pad   = (state_reg == SHOW) && (SW'(pos) >= SW'(len_reg));

    always_comb begin
        seg_next = 8'hFF;
        if (display_on && !show_pad && !blank) begin
            seg_next = buffer[rd_idx];
        end
    end

    // an_reg and seg_reg both derive from the same dig_reg value, so the
    // anode and its pattern always change on the same edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            offset_reg <= '0;
            step_reg   <= '0;
            scan_reg   <= '0;
            dig_reg    <= '0;
            ready_reg  <= 1'b0;
            an_reg     <= 8'hFF;
            seg_reg    <= 8'hFF;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            offset_reg <= offset_next;
            step_reg   <= step_next;
            ready_reg  <= (state_next == IDLE) || (state_next == LOAD);
            if (scan_reg == SCW'(SCAN_DIV - 1)) begin
                scan_reg <= '0;
                dig_reg  <= dig_reg + 3'd1;
            end else begin
                scan_reg <= scan_reg + SCW'(1);
            end
            an_reg  <= display_on ? ~(8'b1 << dig_reg) : 8'hFF;
            seg_reg <= seg_next;
        end
    end

`ifdef SEG7_SCROLL_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    logic [BW-1:0] blink_cnt_reg;
    logic          blank_reg;

    // Held visible and cleared whenever blinking is off, so each blink run
    // starts with a full visible period.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
        end else if (busy_o && blink_i) begin
            if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
                blink_cnt_reg <= '0;
                blank_reg     <= ~blank_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
        end else begin
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
        end
    end
    assign blank = blank_reg;
`else
    assign blank = 1'b0;
`endif

    assign char_ready_o = ready_reg;
    assign busy_o       = display_on;
    assign an_o         = an_reg;
    assign seg_o        = seg_reg;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Self-checking bench for seg7_scroll_ctrl (SCAN_DIV=4, STEP_DIV=64,
// MSG_DEPTH=16; BLINK_DIV=32 when SEG7_SCROLL_BLINK_EN is defined).
// Display expectations come from a timing model of the scan, scroll and
// blink counters; they are queued per frame and popped as digits appear.
module tb_seg7_scroll_ctrl;

    localparam int DEPTH = 16;
    localparam int SCAN  = 4;
    localparam int STEP  = 64;
    localparam int BLINK = 32;

    logic       clk;
    logic       arstn;
    logic       char_valid;
    logic [7:0] char_in;
    logic       char_last;
    logic       char_ready;
    logic       stop;
    logic       busy;
    logic [7:0] an;
    logic [7:0] seg;
`ifdef SEG7_SCROLL_BLINK_EN
    logic       blink;
`endif

    seg7_scroll_ctrl #(
        .MSG_DEPTH (DEPTH),
        .SCAN_DIV  (SCAN),
        .STEP_DIV  (STEP)
`ifdef SEG7_SCROLL_BLINK_EN
        ,
        .BLINK_DIV (BLINK)
`endif
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .char_valid_i (char_valid),
        .char_i       (char_in),
        .char_last_i  (char_last),
        .char_ready_o (char_ready),
        .stop_i       (stop),
        .busy_o       (busy),
        .an_o         (an),
        .seg_o        (seg)
`ifdef SEG7_SCROLL_BLINK_EN
        ,
        .blink_i      (blink)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [7:0] mbuf [DEPTH];
    int mlen;
    int mode;         // 0 dark, 1 show, 2 scroll
    int t0;           // cycle of the accept edge that entered SHOW/SCROLL
    int rel;          // cycle count at reset release
    int blink_start;  // cycle blink was raised, -1 when off

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Outputs seen at the negedge following edge c derive from the
    // counters as they stood after edge c-1.
    function automatic logic [7:0] exp_an(input int c);
        int k;
        if (mode == 0) return 8'hFF;
        k = ((c - 1 - rel) / SCAN) % 8;
        return ~(8'h01 << k);
    endfunction

    function automatic logic [7:0] exp_seg(input int c);
        int k, p, off;
        logic [7:0] r;
        if (mode == 0) return 8'hFF;
        k = ((c - 1 - rel) / SCAN) % 8;
        p = 7 - k;
        if (mode == 1) begin
            r = (p < mlen) ? mbuf[p] : 8'hFF;
        end else begin
            off = ((c - 1 - t0) / STEP) % mlen;
            r = mbuf[(off + p) % mlen];
        end
        if (blink_start >= 0 && (((c - 1 - blink_start) / BLINK) % 2) == 1) r = 8'hFF;
        return r;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic send_char(input logic [7:0] ch, input logic last);
        chk("ready_before_accept", {7'd0, char_ready}, (mode == 0) ? 8'd1 : 8'd0);
        char_valid = 1'b1;
        char_in    = ch;
        char_last  = last;
        @(posedge clk);
        #1;
        if (mode == 0 && mlen < DEPTH) begin
            mbuf[mlen] = ch;
            mlen++;
            if (last || mlen == DEPTH) begin
                mode = (mlen <= 8) ? 1 : 2;
                t0   = cyc;
            end
        end
        @(negedge clk);
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic do_stop(input logic with_char, input logic [7:0] ch);
        stop = 1'b1;
        if (with_char) begin
            char_valid = 1'b1;
            char_in    = ch;
        end
        @(posedge clk);
        #1;
        mode = 0;
        mlen = 0;
        blink_start = -1;
        @(negedge clk);
        stop       = 1'b0;
        char_valid = 1'b0;
        chk("stop_busy", {7'd0, busy}, 8'd0);
        chk("stop_ready", {7'd0, char_ready}, 8'd1);
        @(negedge clk);
        chk("stop_an", an, 8'hFF);
        chk("stop_seg", seg, 8'hFF);
    endtask

    task automatic check_frame(input string tag);
        int c0;
        exp_t e;
        repeat (2) @(negedge clk);
        c0 = cyc;
        for (int j = 0; j < 8; j++) begin
            e.an  = exp_an(c0 + SCAN * j);
            e.seg = exp_seg(c0 + SCAN * j);
            sbq.push_back(e);
        end
        for (int j = 0; j < 8; j++) begin
            if (j > 0) repeat (SCAN) @(negedge clk);
            e = sbq.pop_front();
            chk({tag, "_an"}, an, e.an);
            chk({tag, "_seg"}, seg, e.seg);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        arstn       = 1'b0;
        char_valid  = 1'b0;
        char_in     = 8'h00;
        char_last   = 1'b0;
        stop        = 1'b0;
`ifdef SEG7_SCROLL_BLINK_EN
        blink       = 1'b0;
`endif
        mode        = 0;
        mlen        = 0;
        t0          = 0;
        rel         = 0;
        blink_start = -1;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ready", {7'd0, char_ready}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        arstn = 1'b1;
        rel   = cyc;
        @(posedge clk);
        #1;
        chk("ready_after_release", {7'd0, char_ready}, 8'd1);
        @(negedge clk);

        // Short message F,P,G -> SHOW, left-justified
        send_char(8'h71, 1'b0);
        send_char(8'h31, 1'b0);
        send_char(8'h43, 1'b1);
        chk("show_busy", {7'd0, busy}, 8'd1);
        chk("show_ready", {7'd0, char_ready}, 8'd0);
        check_frame("show_fpg");
        check_frame("show_fpg_again");
        do_stop(1'b0, 8'h00);

        // Ten characters -> SCROLL, through a full wrap of offset
        for (int i = 0; i < 10; i++) send_char(8'h20 + 8'(i), (i == 9));
        chk("scroll_busy", {7'd0, busy}, 8'd1);
        check_frame("scroll_off0");
        wait_until(t0 + 70);
        check_frame("scroll_off1");
        wait_until(t0 + 325);
        check_frame("scroll_off5");
        wait_until(t0 + 645);
        check_frame("scroll_wrap");
        do_stop(1'b0, 8'h00);

        // stop together with an accepted character: character is dropped
        send_char(8'h0A, 1'b0);
        send_char(8'h0B, 1'b0);
        do_stop(1'b1, 8'h5A);
        send_char(8'h66, 1'b1);
        chk("after_drop_busy", {7'd0, busy}, 8'd1);
        check_frame("after_drop_show");
        do_stop(1'b0, 8'h00);

        // Buffer full without char_last_i
        for (int i = 0; i < DEPTH; i++) send_char(8'h40 + 8'(i), 1'b0);
        chk("full_busy", {7'd0, busy}, 8'd1);
        char_valid = 1'b1;
        char_in    = 8'hEE;
        char_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("full_no_ready", {7'd0, char_ready}, 8'd0);
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
        check_frame("full16");

        // Asynchronous reset mid-SCROLL
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        chk("async_rst_an", an, 8'hFF);
        chk("async_rst_seg", seg, 8'hFF);
        chk("async_rst_ready", {7'd0, char_ready}, 8'd0);
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        mode = 0;
        mlen = 0;
        @(negedge clk);
        arstn = 1'b1;
        rel   = cyc;
        chk("rel_ready_before_edge", {7'd0, char_ready}, 8'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_after_edge", {7'd0, char_ready}, 8'd1);
        @(negedge clk);
        check_frame("after_reset_dark");

`ifdef SEG7_SCROLL_BLINK_EN
        // Blink on an 8-character static message
        for (int i = 0; i < 8; i++) send_char(8'h10 + 8'(i), (i == 7));
        repeat (2) @(negedge clk);
        blink       = 1'b1;
        blink_start = cyc;
        repeat (140) begin
            @(negedge clk);
            chk("blink_an", an, exp_an(cyc));
            chk("blink_seg", seg, exp_seg(cyc));
        end
        blink = 1'b0;
        do_stop(1'b0, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
